// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
// Holds the line-format defaults, the parity mode and the receiver FSM state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  // 0 selects even parity (data bits plus parity bit hold an even number of ones).
  localparam logic PARITY_ODD = 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchroniser for one asynchronous input bit.
// RESET_VAL is the value both flops take in reset (1 for an idle-high serial line).
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   MID      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rxd_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 perr_q, perr_d;
  logic                 par_bad;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = ST_START;
      end
      // Restarting the count at the start-bit midpoint puts every later sample mid-bit.
      ST_START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          par_bad_d = (rxd_s != ((^shift_q) ^ PARITY_ODD));
          state_d   = ST_STOP;
        end
      end
`endif
      // A low stop bit outranks a parity error; only clean frames reach the holding register.
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
            if (par_bad) begin
              perr_d = 1'b1;
            end else if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              oerr_d = 1'b1;
            end
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      perr_q  <= perr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
  end
`endif

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx using a frame table, hand-written corner
// sequences and random frames scored against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         gapBits;
    int         expDeliv;
    int         expFerr;
    logic       expBusy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  int total = 0;
  int bad   = 0;
  int validHigh, validRises, ferrCnt, oerrCnt, perrCnt, busyCnt;
  logic prevValid = 1'b0;
  logic [7:0] rxQ[$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  // Outputs are observed on the falling edge; inputs only change just after a rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_valid) validHigh++;
        if (rx_valid && !prevValid) validRises++;
        if (rx_valid && rx_ready) rxQ.push_back(rx_data);
        if (frame_err) ferrCnt++;
        if (overrun_err) oerrCnt++;
        if (parity_err) perrCnt++;
        if (busy) busyCnt++;
      end
      prevValid = rx_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  task automatic clearCounts();
    validHigh = 0; validRises = 0; ferrCnt = 0;
    oerrCnt = 0; perrCnt = 0; busyCnt = 0;
    rxQ.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < DW; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(^d);
`endif
    driveBit(stopBit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic applyParityFrame(input logic [7:0] d, input logic parBit, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < DW; i++) driveBit(d[i]);
    driveBit(parBit);
    driveBit(stopBit);
  endtask
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] expQ[$];
    logic [7:0] d;
    logic       stopOk;
    logic       parOk;
    int         gap;
    int         expFerr;
    int         expPerr;

    vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1, 1, 0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 2, 0, 1, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 1, 1, 0, 1'b0};

    clearCounts();
    tick(3);
    checkOutput("reset_rx_data", 32'(rx_data), 32'(0));
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_errs", 32'({frame_err, overrun_err, parity_err}), 32'(0));
    rst_n = 1'b1;
    tick(CPB);

    $display("[TB] frame table");
    for (int i = 0; i < 5; i++) begin
      clearCounts();
      applyStimulus(vecs[i].data, vecs[i].stopBit);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_deliv", i), 32'(rxQ.size()), 32'(vecs[i].expDeliv));
      checkOutput($sformatf("vec%0d_valid_cycles", i), 32'(validHigh), 32'(vecs[i].expDeliv));
      checkOutput($sformatf("vec%0d_ferr", i), 32'(ferrCnt), 32'(vecs[i].expFerr));
      checkOutput($sformatf("vec%0d_oerr", i), 32'(oerrCnt), 32'(0));
      if (vecs[i].expDeliv != 0)
        checkOutput($sformatf("vec%0d_data", i), 32'(rxQ[0]), 32'(vecs[i].data));
      rxd = 1'b1;
      tick(vecs[i].gapBits * CPB);
    end

    $display("[TB] start-bit glitch");
    clearCounts();
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(2 * CPB);
    checkOutput("glitch_busy_le8", 32'(busyCnt >= 1 && busyCnt <= 8), 32'(1));
    checkOutput("glitch_valid", 32'(validHigh), 32'(0));
    checkOutput("glitch_ferr", 32'(ferrCnt), 32'(0));
    checkOutput("glitch_idle", 32'(busy), 32'(0));

    $display("[TB] framing error then held-low line");
    clearCounts();
    applyStimulus(8'h3C, 1'b0);
    tick(3 * CPB);
    checkOutput("break_busy", 32'(busy), 32'(1));
    checkOutput("break_ferr_once", 32'(ferrCnt), 32'(1));
    rxd = 1'b1;
    tick(CPB);
    checkOutput("break_exit", 32'(busy), 32'(0));
    applyStimulus(8'h55, 1'b1);
    rxd = 1'b1;
    tick(2);
    checkOutput("break_next_count", 32'(rxQ.size()), 32'(1));
    checkOutput("break_next_data", 32'(rxQ[0]), 32'(8'h55));
    checkOutput("break_no_valid_on_err", 32'(validRises), 32'(1));

    $display("[TB] overrun");
    clearCounts();
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1);
    rxd = 1'b1;
    tick(CPB);
    applyStimulus(8'h22, 1'b1);
    rxd = 1'b1;
    tick(CPB);
    checkOutput("ovr_valid", 32'(rx_valid), 32'(1));
    checkOutput("ovr_data", 32'(rx_data), 32'(8'h11));
    checkOutput("ovr_pulses", 32'(oerrCnt), 32'(1));
    rx_ready = 1'b1;
    tick(1);
    checkOutput("ovr_clear", 32'(rx_valid), 32'(0));
    checkOutput("ovr_taken", 32'(rxQ.size()), 32'(1));
    checkOutput("ovr_taken_data", 32'(rxQ[0]), 32'(8'h11));

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    applyStimulus(8'h5A, 1'b1);
    rxd = 1'b1;
    tick(CPB);
    checkOutput("rst_pre_valid", 32'(rx_valid), 32'(1));
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(rx_valid), 32'(0));
    checkOutput("rst_async_data", 32'(rx_data), 32'(0));
    checkOutput("rst_async_busy", 32'(busy), 32'(0));
    tick(2);
    rst_n = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;
    tick(2 * CPB);
    clearCounts();
    applyStimulus(8'h99, 1'b1);
    rxd = 1'b1;
    tick(2);
    checkOutput("rst_next_count", 32'(rxQ.size()), 32'(1));
    checkOutput("rst_next_data", 32'(rxQ[0]), 32'(8'h99));

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity");
    clearCounts();
    applyParityFrame(8'h03, 1'b1, 1'b1);
    rxd = 1'b1;
    tick(CPB);
    checkOutput("par_bad_pulse", 32'(perrCnt), 32'(1));
    checkOutput("par_bad_no_valid", 32'(validHigh), 32'(0));
    applyParityFrame(8'h03, 1'b0, 1'b1);
    rxd = 1'b1;
    tick(2);
    checkOutput("par_good_count", 32'(rxQ.size()), 32'(1));
    checkOutput("par_good_data", 32'(rxQ[0]), 32'(8'h03));
    checkOutput("par_good_no_err", 32'(perrCnt), 32'(1));
    clearCounts();
    applyParityFrame(8'h03, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(CPB);
    checkOutput("par_prec_ferr", 32'(ferrCnt), 32'(1));
    checkOutput("par_prec_perr", 32'(perrCnt), 32'(0));
`endif

    // Model: a low stop bit is a framing error, else a bad parity bit is a parity error,
    // else the byte is delivered in order (consumer always ready).
    $display("[TB] random frames");
    clearCounts();
    expQ.delete();
    expFerr = 0;
    expPerr = 0;
    parOk = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d      = 8'($urandom);
      stopOk = ($urandom_range(7) != 0);
      gap    = $urandom_range(2);
      if (!stopOk && gap == 0) gap = 1;
`ifdef UART_RX_PARITY_EN
      parOk = ($urandom_range(5) != 0);
      applyParityFrame(d, ($countones(d) % 2 == 1) ^ !parOk, stopOk);
`else
      applyStimulus(d, stopOk);
`endif
      if (!stopOk) expFerr++;
      else if (!parOk) expPerr++;
      else expQ.push_back(d);
      rxd = 1'b1;
      tick(gap * CPB);
    end
    tick(CPB);
    checkOutput("rand_count", 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("rand_data%0d", i), 32'(rxQ[i]), 32'(expQ[i]));
    checkOutput("rand_ferr", 32'(ferrCnt), 32'(expFerr));
    checkOutput("rand_perr", 32'(perrCnt), 32'(expPerr));
    checkOutput("rand_oerr", 32'(oerrCnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
